seg_scan_driver: RTL and testbench
==================================

// Module: seg_scan_driver
// PURPOSE
//   Time-multiplexed 4-digit seven-segment driver; the consumer of the per-digit
//   segment patterns produced by the level-meter display logic.
//   Takes four 8-bit active-low patterns (bit7=a .. bit1=g, bit0=dp) and scans the
//   board anodes, with a per-slot ghosting blank.
//   Patterns are double-buffered and applied only at frame boundaries, so a display
//   update never tears mid-frame.
// PARAMETERS
//   TICKS_PER_DIGIT  100000  clock cycles per digit slot (1 kHz/digit at 100 MHz); >=4
//   BLANK_CYCLES     16      cycles at the start of each slot with all anodes off; < TICKS_PER_DIGIT
// PORTS
//   clock           in   1  system clock, rising edge
//   reset           in   1  asynchronous, active-high
//   update_strobe   in   1  1-cycle pulse: capture seg_an3..seg_an0 into staging
//   digit_en        in   4  per-digit enable, bit i = digit i (0 = rightmost); 0 = digit dark
//   seg_an3         in   8  pattern for digit 3 (leftmost), active-low
//   seg_an2         in   8  pattern for digit 2, active-low
//   seg_an1         in   8  pattern for digit 1, active-low
//   seg_an0         in   8  pattern for digit 0, active-low
//   an              out  4  anode selects, active-low, an[i] = digit i
//   seg             out  7  cathodes, active-low, seg[0]=a .. seg[6]=g
//   dp              out  1  decimal point, active-low
//   frame_done      out  1  1-cycle pulse after digit 3's slot completes
//   update_pending  out  1  high from update_strobe until staging is applied
// BEHAVIOUR
//   Reset (async)
//   - cnt=0, idx=0, staging=shadow=8'hFF x4.
//   - an=4'b1111, seg=7'h7F, dp=1, frame_done=0, update_pending=0.
//   Counters
//   - cnt counts 0..TICKS_PER_DIGIT-1 and wraps.
//   - On wrap, idx advances 0->1->2->3->0; a frame is 4*TICKS_PER_DIGIT cycles.
//   Phases (per slot), derived from cnt
//   - BLANK when cnt < BLANK_CYCLES; DRIVE otherwise.
//   Outputs: registered, 1-cycle latency from (idx,cnt)
//   - In DRIVE with digit_en[idx]=1: an = ~(1<<idx), seg[k] = shadow[idx][7-k], dp = shadow[idx][0].
//   - Otherwise (BLANK, or digit disabled): an=1111, seg=7F, dp=1.
//   - digit_en is sampled every cycle, not buffered.
//   Double buffering
//   - update_strobe copies seg_an3..0 into staging and sets update_pending.
//   - Frame boundary = the edge where idx=3 and cnt wraps.
//   - At that edge: if update_pending, shadow<=staging and update_pending clears; frame_done pulses 1 cycle.
//   Boundary cases
//   - Strobe on the boundary edge: shadow takes the OLD staging; staging takes the new inputs;
//     update_pending stays 1 and applies at the next boundary.
//   - Repeated strobes before a boundary: last one wins.
//   - Reset mid-frame: immediate return to the reset state; no partial-pattern output.
// TESTING (TICKS_PER_DIGIT=8, BLANK_CYCLES=2)
//   1. Assert reset mid-DRIVE -> an=1111, seg=7F, dp=1, frame_done=0 at once.
//      After release, all digits dark for the first frame.
//   2. seg_an0=8'b1001_1111, strobe, digit_en=1111
//      -> update_pending=1 until the frame boundary.
//      -> Next frame, slot 0 cycles 2..7: an=1110, seg=7'b1111001, dp=1.
//   3. seg_an3=8'b1110_0011 loaded, digit_en=4'b0111 -> an[3] never 0.
//      Set digit_en[3]=1 -> slot 3: an=0111, seg=7'b1000111.
//   4. Strobe exactly on the boundary edge -> old staging is shown; update_pending stays 1;
//      the new pattern is shown one frame (32 cycles) later.
//   5. Free run -> frame_done pulses every 32 cycles.
//      Within each 8-cycle slot, an=1111 for the first 2 cycles.
//      At most one an bit is 0 in any cycle.

Source files
------------

// File: rtl/seg_scan_if.sv
// Bundle between the level-meter display logic (master) and the
// seven-segment scan driver (slave): pattern inputs plus scanned outputs.
interface seg_scan_if;
    logic       update_strobe;
    logic [3:0] digit_en;
    logic [7:0] seg_an3;
    logic [7:0] seg_an2;
    logic [7:0] seg_an1;
    logic [7:0] seg_an0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_done;
    logic       update_pending;

    modport master (
        output update_strobe, digit_en, seg_an3, seg_an2, seg_an1, seg_an0,
        input  an, seg, dp, frame_done, update_pending
    );

    modport slave (
        input  update_strobe, digit_en, seg_an3, seg_an2, seg_an1, seg_an0,
        output an, seg, dp, frame_done, update_pending
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit seven-segment scan driver with per-slot blanking
// and frame-aligned double buffering of the active-low segment patterns.
module seg_scan_driver #(
    parameter int TICKS_PER_DIGIT = 100000,
    parameter int BLANK_CYCLES    = 16
) (
    input  logic        clock,
    input  logic        reset,
    seg_scan_if.slave   bus
);

    localparam int              CW        = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
    localparam logic [CW-1:0]   CNT_LAST  = CW'(TICKS_PER_DIGIT - 1);
    localparam logic [CW-1:0]   BLANK_END = CW'(BLANK_CYCLES);

    // Pattern byte is a..g in bits 7..1; cathode k takes bit 7-k.
    function automatic logic [6:0] pattern_to_seg(input logic [7:0] pat);
        logic [6:0] s;
        s = 7'h7F;
        for (int k = 0; k < 7; k++) begin
            s[k] = pat[7-k];
        end
        return s;
    endfunction

    function automatic logic [3:0] anode_sel(input logic [1:0] idx);
        logic [3:0] a;
        case (idx)
            2'd0:    a = 4'b1110;
            2'd1:    a = 4'b1101;
            2'd2:    a = 4'b1011;
            2'd3:    a = 4'b0111;
            default: a = 4'b1111;
        endcase
        return a;
    endfunction

    logic [CW-1:0] cnt_r;
    logic [1:0]    idx_r;
    logic [7:0]    staging_r [4];
    logic [7:0]    shadow_r  [4];
    logic          pending_r;
    logic [3:0]    an_r;
    logic [6:0]    seg_r;
    logic          dp_r;
    logic          frame_done_r;

    logic          wrap_s;
    logic          boundary_s;
    logic          blank_s;
    logic          drive_s;
    logic [7:0]    cur_pat_s;
    logic [3:0]    an_nxt_s;
    logic [6:0]    seg_nxt_s;
    logic          dp_nxt_s;

    assign wrap_s     = (cnt_r == CNT_LAST);
    assign boundary_s = wrap_s && (idx_r == 2'd3);
    assign blank_s    = (cnt_r < BLANK_END);
    assign cur_pat_s  = shadow_r[idx_r];
    assign drive_s    = !blank_s && bus.digit_en[idx_r];

    // Next-cycle anode/cathode values for the current slot position.
    always_comb begin
        an_nxt_s  = 4'b1111;
        seg_nxt_s = 7'h7F;
        dp_nxt_s  = 1'b1;
        if (drive_s) begin
            an_nxt_s  = anode_sel(idx_r);
            seg_nxt_s = pattern_to_seg(cur_pat_s);
            dp_nxt_s  = cur_pat_s[0];
        end else begin
            an_nxt_s  = 4'b1111;
            seg_nxt_s = 7'h7F;
            dp_nxt_s  = 1'b1;
        end
    end

    // Slot tick counter and digit index.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_r <= '0;
            idx_r <= 2'd0;
        end else if (wrap_s) begin
            cnt_r <= '0;
            idx_r <= idx_r + 2'd1;
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    // Staging captures on strobe; shadow only changes on a frame boundary,
    // so a strobe landing on the boundary itself waits one more frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                staging_r[i] <= 8'hFF;
                shadow_r[i]  <= 8'hFF;
            end
            pending_r <= 1'b0;
        end else begin
            if (boundary_s && pending_r) begin
                for (int i = 0; i < 4; i++) begin
                    shadow_r[i] <= staging_r[i];
                end
            end
            if (bus.update_strobe) begin
                staging_r[3] <= bus.seg_an3;
                staging_r[2] <= bus.seg_an2;
                staging_r[1] <= bus.seg_an1;
                staging_r[0] <= bus.seg_an0;
                pending_r    <= 1'b1;
            end else if (boundary_s) begin
                pending_r    <= 1'b0;
            end
        end
    end

    // Registered board outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            an_r         <= 4'b1111;
            seg_r        <= 7'h7F;
            dp_r         <= 1'b1;
            frame_done_r <= 1'b0;
        end else begin
            an_r         <= an_nxt_s;
            seg_r        <= seg_nxt_s;
            dp_r         <= dp_nxt_s;
            frame_done_r <= boundary_s;
        end
    end

    assign bus.an             = an_r;
    assign bus.seg            = seg_r;
    assign bus.dp             = dp_r;
    assign bus.frame_done     = frame_done_r;
    assign bus.update_pending = pending_r;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver (8 ticks/digit, 2 blank cycles): per-cycle
// scoreboard against a position-based model, vector table and corner sequences.
module tb_seg_scan_driver;

    localparam int TPD = 8;
    localparam int BLK = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;

    seg_scan_if bus();

    seg_scan_driver #(.TICKS_PER_DIGIT(TPD), .BLANK_CYCLES(BLK)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
        logic       up;
    } exp_t;

    typedef struct {
        int         digit;
        int         cyc;
        logic [7:0] pat;
        logic [3:0] en;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } vec_t;

    exp_t       sb_q[$];
    int         compared   = 0;
    int         mismatched = 0;
    logic [7:0] stg_m [4];
    logic [7:0] sh_m  [4];
    logic       pend_m;
    int         k_m;
    vec_t       vecs [8];

    function automatic logic [6:0] decode(input logic [7:0] p);
        return {p[1], p[2], p[3], p[4], p[5], p[6], p[7]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: position in the frame follows from edges since reset.
    always @(posedge clock or posedge reset) begin
        int   p;
        int   c;
        int   d;
        logic bnd;
        exp_t e;
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                stg_m[i] = 8'hFF;
                sh_m[i]  = 8'hFF;
            end
            pend_m = 1'b0;
            k_m    = 0;
            sb_q.delete();
        end else begin
            p   = k_m;
            k_m = k_m + 1;
            c   = p % TPD;
            d   = (p / TPD) % 4;
            bnd = (c == TPD - 1) && (d == 3);
            e.an  = 4'b1111;
            e.seg = 7'h7F;
            e.dp  = 1'b1;
            if (c >= BLK && bus.digit_en[d]) begin
                e.an[d] = 1'b0;
                e.seg   = decode(sh_m[d]);
                e.dp    = sh_m[d][0];
            end
            e.fd = bnd;
            if (bnd && pend_m) begin
                for (int i = 0; i < 4; i++) sh_m[i] = stg_m[i];
            end
            if (bus.update_strobe) begin
                stg_m[3] = bus.seg_an3;
                stg_m[2] = bus.seg_an2;
                stg_m[1] = bus.seg_an1;
                stg_m[0] = bus.seg_an0;
                pend_m   = 1'b1;
            end else if (bnd) begin
                pend_m = 1'b0;
            end
            e.up = pend_m;
            sb_q.push_back(e);
        end
    end

    // Scoreboard pop on the falling edge, away from the register updates.
    always @(negedge clock) begin
        exp_t e;
        if (!reset && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("scoreboard", {bus.an, bus.seg, bus.dp, bus.frame_done, bus.update_pending}, e);
            check("an_at_most_one", 32'($countones(~bus.an) <= 1), 32'd1);
        end
    end

    task automatic set_pats(input int d, input logic [7:0] pat);
        bus.seg_an3 = (d == 3) ? pat : 8'hFF;
        bus.seg_an2 = (d == 2) ? pat : 8'hFF;
        bus.seg_an1 = (d == 1) ? pat : 8'hFF;
        bus.seg_an0 = (d == 0) ? pat : 8'hFF;
    endtask

    task automatic wait_fd();
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!bus.frame_done && n < 100);
        check("frame_done_seen", 32'(bus.frame_done), 32'd1);
    endtask

    task automatic strobe(input int d, input logic [7:0] pat);
        @(posedge clock);
        #1;
        set_pats(d, pat);
        bus.update_strobe = 1'b1;
        @(posedge clock);
        #1;
        bus.update_strobe = 1'b0;
    endtask

    initial begin
        int n;
        vecs[0] = '{0, 4, 8'h9F, 4'b1111, 4'b1110, 7'b1111001, 1'b1};
        vecs[1] = '{3, 4, 8'hE3, 4'b0111, 4'b1111, 7'h7F,      1'b1};
        vecs[2] = '{3, 4, 8'hE3, 4'b1111, 4'b0111, 7'b1000111, 1'b1};
        vecs[3] = '{1, 7, 8'h00, 4'b1111, 4'b1101, 7'b0000000, 1'b0};
        vecs[4] = '{2, 2, 8'h02, 4'b1111, 4'b1011, 7'b1000000, 1'b0};
        vecs[5] = '{2, 4, 8'hFE, 4'b1111, 4'b1011, 7'h7F,      1'b0};
        vecs[6] = '{0, 1, 8'h9F, 4'b1111, 4'b1111, 7'h7F,      1'b1};
        vecs[7] = '{3, 0, 8'hE3, 4'b1111, 4'b1111, 7'h7F,      1'b1};

        bus.update_strobe = 1'b0;
        bus.digit_en      = 4'b1111;
        set_pats(0, 8'hFF);
        repeat (3) @(negedge clock);
        check("reset_state", {bus.an, bus.seg, bus.dp, bus.frame_done, bus.update_pending},
              {4'b1111, 7'h7F, 1'b1, 1'b0, 1'b0});
        #2 reset = 1'b0;

        // Table: load one digit mid-frame, check it in the frame after the boundary.
        for (int i = 0; i < 8; i++) begin
            wait_fd();
            bus.digit_en = vecs[i].en;
            strobe(vecs[i].digit, vecs[i].pat);
            wait_fd();
            repeat (vecs[i].digit * TPD + vecs[i].cyc + 1) @(negedge clock);
            check($sformatf("vec%0d", i), {bus.an, bus.seg, bus.dp},
                  {vecs[i].an, vecs[i].seg, vecs[i].dp});
        end

        // Strobe on the boundary edge: old staging shown, new one a frame later.
        bus.digit_en = 4'b1111;
        wait_fd();
        @(posedge clock);
        #1;
        set_pats(0, 8'h00);
        bus.update_strobe = 1'b1;
        @(posedge clock);
        #1;
        set_pats(0, 8'h9F);
        @(posedge clock);
        #1;
        bus.update_strobe = 1'b0;
        repeat (28) @(posedge clock);
        #1;
        set_pats(0, 8'b0110_0000);
        bus.update_strobe = 1'b1;
        @(posedge clock);
        #1;
        bus.update_strobe = 1'b0;
        @(negedge clock);
        check("boundary_fd", 32'(bus.frame_done), 32'd1);
        check("pending_kept", 32'(bus.update_pending), 32'd1);
        repeat (5) @(negedge clock);
        check("old_staging_shown", {bus.an, bus.seg, bus.dp}, {4'b1110, 7'b1111001, 1'b1});
        wait_fd();
        check("pending_cleared", 32'(bus.update_pending), 32'd0);
        repeat (5) @(negedge clock);
        check("new_staging_shown", {bus.an, bus.seg, bus.dp}, {4'b1110, 7'b0000110, 1'b0});

        // Asynchronous reset in the middle of a DRIVE phase.
        wait_fd();
        repeat (4) @(negedge clock);
        check("drive_before_reset", 32'(bus.an), 32'(4'b1110));
        #2 reset = 1'b1;
        #1;
        check("async_reset", {bus.an, bus.seg, bus.dp, bus.frame_done, bus.update_pending},
              {4'b1111, 7'h7F, 1'b1, 1'b0, 1'b0});
        @(negedge clock);
        #2 reset = 1'b0;
        for (int j = 0; j < 4 * TPD; j++) begin
            @(negedge clock);
            check("dark_first_frame", {bus.seg, bus.dp}, {7'h7F, 1'b1});
        end

        // Free run: frame_done period.
        wait_fd();
        for (int f = 0; f < 3; f++) begin
            n = 0;
            do begin
                @(negedge clock);
                n++;
            end while (!bus.frame_done && n < 100);
            check("frame_period", 32'(n), 32'd32);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
